data_memory_be: RTL and testbench

//   Parametrised single-port data memory for the EU load/store path: configurable width/depth,
//   per-byte write enables, registered read with valid strobe, address range check, and a

---
 rtl/dmem_pkg.sv | 8 +
 rtl/dmem_clear_seq.sv | 56 +++++
 rtl/data_memory_be.sv | 74 +++++++
 tb/tb_data_memory_be.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-enabled data memory.
package dmem_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} dmem_state_e;

    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction
endpackage

// File: rtl/dmem_clear_seq.sv
// Clear sequencer: walks a pointer over every implemented word, issuing zero writes.
module dmem_clear_seq
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 1 << ADDR_W,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              idle,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    dmem_state_e       state;
    logic [ADDR_W-1:0] ptr;
    // Holds off requests for the one IDLE cycle before the power-on clear starts.
    logic              start_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            busy       <= 1'b0;
            start_pend <= (CLEAR_ON_RESET != 0);
        end else begin
            start_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req || start_pend) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign idle     = (state == IDLE) && !start_pend;
    assign clr_we   = (state == CLEAR);
    assign clr_addr = ptr;
endmodule

// File: rtl/data_memory_be.sv
// Single-port data memory with byte enables, registered read, range check and clear sequencer.
module data_memory_be
    import dmem_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 1 << ADDR_W,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear_req,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic [DATA_W/8-1:0]    req_be,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   busy,
    output logic                   addr_err
);
    localparam int              BE_W    = be_w(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              seq_idle;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              accept;
    logic              in_range;

    dmem_clear_seq #(
        .ADDR_W        (ADDR_W),
        .DEPTH         (DEPTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_req(clear_req),
        .idle     (seq_idle),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign req_ready = seq_idle && !clear_req;
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < DEPTH_X;

    // Array itself is never reset; only the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (accept && req_we && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            addr_err  <= 1'b0;
        end else begin
            rsp_valid <= accept && !req_we;
            addr_err  <= accept && !in_range;
            if (accept && !req_we) rsp_rdata <= in_range ? mem[req_addr] : '0;
        end
    end
endmodule

// File: tb/tb_data_memory_be.sv
// Bench for data_memory_be: 8-bit/256-word instance (dut 0) and 32-bit/200-word instance (dut 1).
module tb_data_memory_be;
    typedef struct {
        int          dut;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          dut;
        logic        is_read;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    int          sel = 0;

    logic [1:0]       rv, ae, bsy, rdy;
    logic [1:0][31:0] rd;
    logic [7:0]       a_rdata;
    logic [31:0]      b_rdata;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;
    exp_t sbq[$];
    exp_t e;
    logic [1:0] due;
    vec_t tv[16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    data_memory_be #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req && sel == 0),
        .req_valid(req_valid && sel == 0), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata[7:0]), .req_be(req_be[0:0]),
        .rsp_valid(rv[0]), .rsp_rdata(a_rdata), .busy(bsy[0]), .addr_err(ae[0]));

    data_memory_be #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req && sel == 1),
        .req_valid(req_valid && sel == 1), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv[1]), .rsp_rdata(b_rdata), .busy(bsy[1]), .addr_err(ae[1]));

    assign rd[0] = {24'b0, a_rdata};
    assign rd[1] = b_rdata;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Scoreboard: each accepted request is due exactly one cycle after its accept edge.
    always @(negedge clk) begin
        if (mon_en) begin
            due = '0;
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                chk("rsp_late", cyc, e.cyc);
            end
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                due[e.dut] = 1'b1;
                chk("rsp_valid", {31'b0, rv[e.dut]}, {31'b0, e.is_read});
                if (e.is_read) chk("rsp_rdata", rd[e.dut], e.rdata);
                chk("addr_err", {31'b0, ae[e.dut]}, {31'b0, e.err});
            end
            for (int d = 0; d < 2; d++) begin
                if (!due[d]) begin
                    chk("idle_rsp_valid", {31'b0, rv[d]}, 32'd0);
                    chk("idle_addr_err", {31'b0, ae[d]}, 32'd0);
                end
            end
        end
    end

    task automatic issue(input vec_t v, input logic exp_acc);
        exp_t r;
        @(negedge clk);
        sel       = v.dut;
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
        #1;
        chk("req_ready", {31'b0, rdy[v.dut]}, {31'b0, exp_acc});
        if (rdy[v.dut]) begin
            r.dut = v.dut; r.is_read = !v.we; r.rdata = v.exp_rd; r.err = v.exp_err; r.cyc = cyc + 1;
            sbq.push_back(r);
        end
    endtask

    task automatic rd_req(input int d, input logic [7:0] a, input logic [31:0] exp, input logic err);
        vec_t v;
        v = '{d, 1'b0, a, 32'h0, 4'h0, exp, err};
        issue(v, 1'b1);
    endtask

    task automatic wr_req(input int d, input logic [7:0] a, input logic [31:0] w, input logic [3:0] be);
        vec_t v;
        v = '{d, 1'b1, a, w, be, 32'h0, 1'b0};
        issue(v, 1'b1);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        req_valid = 1'b0;
        clear_req = 1'b0;
    endtask

    // Counts busy cycles of dut d over a fixed window and flags any cycle with ready during busy.
    task automatic count_busy(input int d, input int win, output int cnt, output int bad);
        cnt = 0; bad = 0;
        for (int k = 0; k < win; k++) begin
            @(negedge clk);
            #1;
            if (bsy[d]) cnt++;
            if (bsy[d] && rdy[d]) bad++;
        end
    endtask

    initial begin
        int cnt, bad, cnt_b, k;
        tv[0]  = '{1, 1'b1, 8'd5,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tv[1]  = '{1, 1'b1, 8'd5,   32'h11223344, 4'h5, 32'h0,        1'b0};
        tv[2]  = '{1, 1'b0, 8'd5,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        tv[3]  = '{1, 1'b1, 8'd210, 32'h12345678, 4'hF, 32'h0,        1'b1};
        tv[4]  = '{1, 1'b0, 8'd210, 32'h0,        4'h0, 32'h0,        1'b1};
        tv[5]  = '{1, 1'b0, 8'd5,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        tv[6]  = '{1, 1'b1, 8'd7,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        tv[7]  = '{1, 1'b0, 8'd7,   32'h0,        4'h0, 32'h0,        1'b0};
        tv[8]  = '{1, 1'b1, 8'd199, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        tv[9]  = '{1, 1'b0, 8'd199, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        tv[10] = '{1, 1'b0, 8'd200, 32'h0,        4'h0, 32'h0,        1'b1};
        tv[11] = '{0, 1'b1, 8'd3,   32'h000000A5, 4'h1, 32'h0,        1'b0};
        tv[12] = '{0, 1'b0, 8'd3,   32'h0,        4'h0, 32'hA5,       1'b0};
        tv[13] = '{0, 1'b0, 8'd3,   32'h0,        4'h0, 32'hA5,       1'b0};
        tv[14] = '{0, 1'b0, 8'd4,   32'h0,        4'h0, 32'h0,        1'b0};
        tv[15] = '{0, 1'b0, 8'd3,   32'h0,        4'h0, 32'hA5,       1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", {31'b0, bsy[d]}, 32'd0);
            chk("rst_rsp_valid", {31'b0, rv[d]}, 32'd0);
            chk("rst_rdata", rd[d], 32'd0);
            chk("rst_addr_err", {31'b0, ae[d]}, 32'd0);
        end

        // Power-on clear: one holdoff cycle, then DEPTH busy cycles
        reset_n = 1'b1;
        mon_en  = 1'b1;
        #1;
        chk("pend_ready_a", {31'b0, rdy[0]}, 32'd0);
        chk("pend_ready_b", {31'b0, rdy[1]}, 32'd0);
        cnt = 0; cnt_b = 0; bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (bsy[0]) cnt++;
            if (bsy[1]) cnt_b++;
            if ((bsy[0] && rdy[0]) || (bsy[1] && rdy[1])) bad++;
        end
        chk("por_clear_len_a", cnt, 256);
        chk("por_clear_len_b", cnt_b, 200);
        chk("por_ready_while_busy", bad, 0);
        for (int i = 0; i < 256; i++) rd_req(0, 8'(i), 32'h0, 1'b0);
        idle_bus();

        // Table: byte merge, range errors, back-to-back reads
        for (int i = 0; i < 16; i++) issue(tv[i], 1'b1);
        idle_bus();
        @(negedge clk);
        chk("rdata_hold_a", rd[0], 32'hA5);
        chk("rdata_hold_b", rd[1], 32'h0);

        // clear_req beats a same-cycle read; second clear_req mid-clear is ignored
        @(negedge clk);
        sel = 0; clear_req = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd3;
        #1;
        chk("clear_blocks_req", {31'b0, rdy[0]}, 32'd0);
        @(negedge clk);
        clear_req = 1'b0; req_valid = 1'b0;
        cnt = 0; bad = 0;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (bsy[0]) cnt++;
            if (bsy[0] && rdy[0]) bad++;
            clear_req = bsy[0] && (cnt == 50);
            @(negedge clk);
        end
        clear_req = 1'b0;
        chk("clear_len", cnt, 256);
        chk("clear_ready_while_busy", bad, 0);
        rd_req(0, 8'd3, 32'h0, 1'b0);
        wr_req(0, 8'd9, 32'h3C, 4'h1);
        rd_req(0, 8'd9, 32'h3C, 1'b0);
        idle_bus();
        @(negedge clk);

        // Reset at clear cycle 100 aborts; clear restarts and runs a full DEPTH
        sel = 0; clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        k = 0;
        cnt = 0;
        while (cnt < 100 && k < 500) begin
            #1;
            if (bsy[0]) cnt++;
            if (cnt < 100) @(negedge clk);
            k++;
        end
        chk("reach_clear_100", cnt, 100);
        @(negedge clk);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, bsy[0]}, 32'd0);
        chk("abort_rsp_valid", {31'b0, rv[0]}, 32'd0);
        chk("abort_rdata", rd[0], 32'd0);
        chk("abort_addr_err", {31'b0, ae[0]}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        #1;
        chk("restart_pend_ready", {31'b0, rdy[0]}, 32'd0);
        count_busy(0, 300, cnt, bad);
        chk("restart_clear_len", cnt, 256);
        chk("restart_ready_while_busy", bad, 0);
        rd_req(0, 8'd9, 32'h0, 1'b0);
        rd_req(0, 8'd255, 32'h0, 1'b0);
        idle_bus();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
